coregpio_bfm_apb_initiator: RTL and testbench

//  APB3 initiator BFM on the PCLK_PM domain. Accepts single read/write commands on a

---
 rtl/coregpio_bfm_apb_initiator.sv | 182 ++++++++++++++++++
 tb/tb_coregpio_bfm_apb_initiator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/coregpio_bfm_apb_initiator.sv
// rtl/coregpio_bfm_apb_initiator.sv - APB3 initiator BFM: one command in, SETUP/ACCESS on the *_PM bus, one response out
// Bounded wait-state timeout, sticky protocol-error flag, single transfer outstanding.
module coregpio_bfm_apb_initiator #(
  parameter int TIMEOUT  = 256,
  parameter int IDLE_GAP = 1
) (
  input  logic        PCLK_PM,
  input  logic        PRESETN_PM,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_SLVERR,
  output logic        RSP_TIMEOUT,
  output logic        PROTO_ERR,
  output logic [15:0] TXN_COUNT,
  output logic        PSEL_PM,
  output logic [31:0] PADDR_PM,
  output logic        PWRITE_PM,
  output logic        PENABLE_PM,
  output logic [31:0] PWDATA_PM,
  input  logic [31:0] PRDATA_PM,
  input  logic        PREADY_PM,
  input  logic        PSLVERR_PM
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP} state_t;

  localparam bit          TO_EN    = (TIMEOUT > 0);
  localparam logic [15:0] TO_LAST  = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;
  localparam logic [15:0] GAP_LAST = (IDLE_GAP > 1) ? 16'(IDLE_GAP - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_slverr_q, rsp_slverr_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        proto_err_q, proto_err_d;
  logic [15:0] txn_count_q, txn_count_d;
  logic        psel_q, psel_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic        penable_q, penable_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        accept;
  logic        finish;
  logic        abort;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = 1'b0;
    proto_err_d   = proto_err_q;
    txn_count_d   = txn_count_q;
    psel_d        = psel_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    penable_d     = penable_q;
    pwdata_d      = pwdata_q;
    accept        = CMD_VALID && cmd_ready_q;
    finish        = 1'b0;
    abort         = 1'b0;

    // PREADY is only meaningful in ACCESS; anywhere else it is a slave protocol violation.
    if (state_q != ST_ACCESS && PREADY_PM) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = !accept;
        if (accept) begin
          psel_d   = 1'b1;
          paddr_d  = CMD_ADDR;
          pwrite_d = CMD_WRITE;
          pwdata_d = CMD_WRITE ? CMD_WDATA : 32'd0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 16'd0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready on the final allowed edge takes priority over the abort.
        if (PREADY_PM) begin
          finish = 1'b1;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          finish = 1'b1;
          abort  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (finish) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = abort;
          rsp_rdata_d   = (abort || pwrite_q) ? 32'd0 : PRDATA_PM;
          rsp_slverr_d  = abort ? 1'b1 : PSLVERR_PM;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          paddr_d       = 32'd0;
          pwdata_d      = 32'd0;
          pwrite_d      = 1'b0;
          txn_count_d   = txn_count_q + 16'd1;
          cnt_d         = 16'd0;
          state_d       = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cmd_ready_d = 1'b1;
          cnt_d       = 16'd0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      proto_err_q   <= 1'b0;
      txn_count_q   <= 16'd0;
      psel_q        <= 1'b0;
      paddr_q       <= 32'd0;
      pwrite_q      <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      proto_err_q   <= proto_err_d;
      txn_count_q   <= txn_count_d;
      psel_q        <= psel_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      penable_q     <= penable_d;
      pwdata_q      <= pwdata_d;
    end
  end

  assign CMD_READY   = cmd_ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_SLVERR  = rsp_slverr_q;
  assign RSP_TIMEOUT = rsp_timeout_q;
  assign PROTO_ERR   = proto_err_q;
  assign TXN_COUNT   = txn_count_q;
  assign PSEL_PM     = psel_q;
  assign PADDR_PM    = paddr_q;
  assign PWRITE_PM   = pwrite_q;
  assign PENABLE_PM  = penable_q;
  assign PWDATA_PM   = pwdata_q;

endmodule

// File: tb/tb_coregpio_bfm_apb_initiator.sv
// tb/tb_coregpio_bfm_apb_initiator.sv - randomized bench for the APB initiator BFM against a transaction-level model
module tb_coregpio_bfm_apb_initiator;

  localparam int TO = 8;
  localparam int IG = 2;

  logic        PCLK_PM = 1'b0;
  logic        PRESETN_PM = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = 32'd0;
  logic [31:0] CMD_WDATA = 32'd0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_SLVERR;
  logic        RSP_TIMEOUT;
  logic        PROTO_ERR;
  logic [15:0] TXN_COUNT;
  logic        PSEL_PM;
  logic [31:0] PADDR_PM;
  logic        PWRITE_PM;
  logic        PENABLE_PM;
  logic [31:0] PWDATA_PM;
  logic [31:0] PRDATA_PM = 32'd0;
  logic        PREADY_PM = 1'b0;
  logic        PSLVERR_PM = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_proto = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_slverr = 1'b0;

  coregpio_bfm_apb_initiator #(.TIMEOUT(TO), .IDLE_GAP(IG)) dut (
    .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_SLVERR(RSP_SLVERR),
    .RSP_TIMEOUT(RSP_TIMEOUT), .PROTO_ERR(PROTO_ERR), .TXN_COUNT(TXN_COUNT),
    .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM), .PWRITE_PM(PWRITE_PM),
    .PENABLE_PM(PENABLE_PM), .PWDATA_PM(PWDATA_PM), .PRDATA_PM(PRDATA_PM),
    .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM)
  );

  always #5 PCLK_PM = ~PCLK_PM;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK_PM);
    @(negedge PCLK_PM);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(CMD_READY), 32'd0);
    chk({tag, "_rspv"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_rdata"}, RSP_RDATA, 32'd0);
    chk({tag, "_slverr"}, 32'(RSP_SLVERR), 32'd0);
    chk({tag, "_tout"}, 32'(RSP_TIMEOUT), 32'd0);
    chk({tag, "_proto"}, 32'(PROTO_ERR), 32'd0);
    chk({tag, "_cnt"}, 32'(TXN_COUNT), 32'd0);
    chk({tag, "_psel"}, 32'(PSEL_PM), 32'd0);
    chk({tag, "_penable"}, 32'(PENABLE_PM), 32'd0);
    chk({tag, "_paddr"}, PADDR_PM, 32'd0);
    chk({tag, "_pwrite"}, 32'(PWRITE_PM), 32'd0);
    chk({tag, "_pwdata"}, PWDATA_PM, 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(CMD_READY), 32'd1);
  endtask

  // One command end to end; the slave answers after `waits` wait states unless the timeout fires first.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input logic serr);
    bit          to;
    int          rk;
    logic [31:0] exp_pw;
    to     = (waits >= TO);
    rk     = to ? TO - 1 : waits;
    exp_pw = wr ? wdata : 32'd0;
    wait_ready();
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    tick();
    chk("setup_ready", 32'(CMD_READY), 32'd0);
    chk("setup_psel", 32'(PSEL_PM), 32'd1);
    chk("setup_penable", 32'(PENABLE_PM), 32'd0);
    chk("setup_paddr", PADDR_PM, addr);
    chk("setup_pwrite", 32'(PWRITE_PM), 32'(wr));
    chk("setup_pwdata", PWDATA_PM, exp_pw);
    CMD_WRITE = ~wr;
    CMD_ADDR  = $urandom;
    CMD_WDATA = $urandom;
    tick();
    chk("access_psel", 32'(PSEL_PM), 32'd1);
    chk("access_penable", 32'(PENABLE_PM), 32'd1);
    for (int k = 0; k < rk; k++) begin
      PREADY_PM  = 1'b0;
      PRDATA_PM  = $urandom;
      PSLVERR_PM = 1'($urandom);
      tick();
      chk("wait_rspv", 32'(RSP_VALID), 32'd0);
      chk("wait_penable", 32'(PENABLE_PM), 32'd1);
      chk("wait_paddr", PADDR_PM, addr);
      chk("wait_pwrite", 32'(PWRITE_PM), 32'(wr));
      chk("wait_pwdata", PWDATA_PM, exp_pw);
    end
    PREADY_PM  = !to;
    PRDATA_PM  = rdata;
    PSLVERR_PM = serr;
    tick();
    PREADY_PM  = 1'b0;
    PSLVERR_PM = 1'b0;
    exp_cnt    = exp_cnt + 16'd1;
    exp_rdata  = (wr || to) ? 32'd0 : rdata;
    exp_slverr = to ? 1'b1 : serr;
    chk("rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(to));
    chk("rsp_slverr", 32'(RSP_SLVERR), 32'(exp_slverr));
    chk("rsp_rdata", RSP_RDATA, exp_rdata);
    chk("rsp_psel", 32'(PSEL_PM), 32'd0);
    chk("rsp_penable", 32'(PENABLE_PM), 32'd0);
    chk("rsp_paddr", PADDR_PM, 32'd0);
    chk("rsp_pwdata", PWDATA_PM, 32'd0);
    chk("rsp_pwrite", 32'(PWRITE_PM), 32'd0);
    chk("txn_count", 32'(TXN_COUNT), 32'(exp_cnt));
    chk("proto_err", 32'(PROTO_ERR), 32'(exp_proto));
    for (int g = 1; g <= IG; g++) begin
      tick();
      chk("gap_ready", 32'(CMD_READY), 32'(g == IG));
      chk("gap_rspv", 32'(RSP_VALID), 32'd0);
      chk("gap_tout", 32'(RSP_TIMEOUT), 32'd0);
      chk("gap_rdata_hold", RSP_RDATA, exp_rdata);
      chk("gap_slverr_hold", 32'(RSP_SLVERR), 32'(exp_slverr));
      chk("gap_penable", 32'(PENABLE_PM), 32'd0);
      chk("gap_psel", 32'(PSEL_PM), 32'd0);
    end
  endtask

  task automatic proto_pulse();
    CMD_VALID = 1'b0;
    PREADY_PM = 1'b1;
    tick();
    PREADY_PM = 1'b0;
    exp_proto = 1'b1;
    chk("proto_set", 32'(PROTO_ERR), 32'd1);
    chk("proto_no_psel", 32'(PSEL_PM), 32'd0);
    tick();
    chk("proto_sticky", 32'(PROTO_ERR), 32'd1);
  endtask

  task automatic reset_mid_access(input int waits_before);
    wait_ready();
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = $urandom;
    CMD_WDATA = $urandom;
    tick();
    tick();
    for (int k = 0; k < waits_before; k++) tick();
    chk("pre_rst_penable", 32'(PENABLE_PM), 32'd1);
    CMD_VALID  = 1'b0;
    PRESETN_PM = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge PCLK_PM);
    PREADY_PM = 1'b1;
    tick();
    PREADY_PM = 1'b0;
    chk("rst_hold_rspv", 32'(RSP_VALID), 32'd0);
    PRESETN_PM = 1'b1;
    exp_cnt    = 16'd0;
    exp_proto  = 1'b0;
    exp_rdata  = 32'd0;
    exp_slverr = 1'b0;
    chk("rel_ready_before", 32'(CMD_READY), 32'd0);
    tick();
    chk("rel_ready", 32'(CMD_READY), 32'd1);
    chk("rel_rspv", 32'(RSP_VALID), 32'd0);
    chk("rel_proto", 32'(PROTO_ERR), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge PCLK_PM);
    chk_all_zero("reset");
    PRESETN_PM = 1'b1;
    tick();
    chk("first_ready", 32'(CMD_READY), 32'd1);
    chk("first_proto", 32'(PROTO_ERR), 32'd0);

    run_txn(1'b1, 32'h0100_0004, 32'hA5A5_5A5A, 32'h1234_5678, 0, 1'b0);
    run_txn(1'b0, 32'h0200_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    run_txn(1'b0, 32'h0300_0020, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
    run_txn(1'b0, 32'h0400_0030, 32'h0, 32'h5555_AAAA, 50, 1'b0);
    proto_pulse();
    run_txn(1'b0, 32'h0500_0040, 32'h0, 32'h0BAD_CAFE, TO - 1, 1'b0);
    run_txn(1'b1, 32'h0600_0050, 32'h7777_8888, 32'h0, TO, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 10)), ($urandom_range(0, 3) == 0));
    end

    reset_mid_access(2);

    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 9)), 1'($urandom));
    end

    CMD_VALID = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
